// File: rtl/cache_port_arbiter_if.sv
// Port-side and cache-side signals of cache_port_arbiter.
// master = CPU pipeline plus cache model; slave = the arbiter.
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p1_req;
    logic              p0_we;
    logic              p1_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p1_wdata;
    logic              p0_ready;
    logic              p1_ready;
    logic [DATA_W-1:0] p0_rdata;
    logic [DATA_W-1:0] p1_rdata;
    logic              c_rd_req;
    logic              c_wr_req;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wr_data;
    logic [DATA_W-1:0] c_rd_data;
    logic              c_miss;

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        output c_rd_data, c_miss,
        input  p0_ready, p1_ready, p0_rdata, p1_rdata,
        input  c_rd_req, c_wr_req, c_addr, c_wr_data
    );

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  c_rd_data, c_miss,
        output p0_ready, p1_ready, p0_rdata, p1_rdata,
        output c_rd_req, c_wr_req, c_addr, c_wr_data
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache between I-fetch (port 0) and data (port 1).
// Define CACHE_ARB_PERF_CNT_EN to build the performance counters; otherwise they read 0.
module cache_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    cache_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0] p0_acc_cnt,
    output logic [CNT_W-1:0] p1_acc_cnt,
    output logic [CNT_W-1:0] p0_miss_cnt,
    output logic [CNT_W-1:0] p1_miss_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} state_t;

    state_t                           state;
    req_t   [NUM_PORTS-1:0]           port_req;
    logic   [NUM_PORTS-1:0]           req_vld;
    req_t                             req_q;
    logic                             gnt_id;
    logic                             last;
    logic                             win;
    logic                             c_rd_req;
    logic                             c_wr_req;
    logic                             xfer_done;
    logic   [NUM_PORTS-1:0]           done;
    logic   [NUM_PORTS-1:0]           ready;
    logic   [NUM_PORTS-1:0][DATA_W-1:0] rdata;

    assign req_vld     = {bus.p1_req, bus.p0_req};
    assign port_req[0] = {bus.p0_we, bus.p0_addr, bus.p0_wdata};
    assign port_req[1] = {bus.p1_we, bus.p1_addr, bus.p1_wdata};

    // On a tie the port not served last wins; otherwise the lone requester.
    assign win = (req_vld[0] & req_vld[1]) ? ~last : req_vld[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            req_q    <= '0;
            gnt_id   <= 1'b0;
            last     <= 1'b1;
            c_rd_req <= 1'b0;
            c_wr_req <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req_vld) begin
                        gnt_id   <= win;
                        req_q    <= port_req[win];
                        c_rd_req <= ~port_req[win].we;
                        c_wr_req <= port_req[win].we;
                        state    <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (!bus.c_miss) begin
                        c_rd_req <= 1'b0;
                        c_wr_req <= 1'b0;
                        last     <= gnt_id;
                        state    <= ARB_RESP;
                    end
                end
                ARB_RESP: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

    assign xfer_done = (state == ARB_ISSUE) && !bus.c_miss;
    assign done      = {xfer_done & gnt_id, xfer_done & ~gnt_id};

    cache_port_arbiter_lane #(.DATA_W(DATA_W)) u_lane [NUM_PORTS-1:0] (
        .clk     (clk),
        .rst     (rst),
        .done    (done),
        .rd      (~req_q.we),
        .rd_data (bus.c_rd_data),
        .ready   (ready),
        .rdata   (rdata)
    );

    assign bus.c_rd_req  = c_rd_req;
    assign bus.c_wr_req  = c_wr_req;
    assign bus.c_addr    = req_q.addr;
    assign bus.c_wr_data = req_q.wdata;
    assign bus.p0_ready  = ready[0];
    assign bus.p1_ready  = ready[1];
    assign bus.p0_rdata  = rdata[0];
    assign bus.p1_rdata  = rdata[1];

`ifdef CACHE_ARB_PERF_CNT_EN
    logic [NUM_PORTS-1:0][CNT_W-1:0] acc_cnt;
    logic [NUM_PORTS-1:0][CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0]                stall_q;
    logic                            first_q;

    // first_q marks the first ISSUE cycle of an access, so a miss is counted once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt  <= '0;
            miss_cnt <= '0;
            stall_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            if (state == ARB_IDLE)       first_q <= 1'b1;
            else if (state == ARB_ISSUE) first_q <= 1'b0;
            if (state == ARB_RESP)
                acc_cnt[gnt_id] <= acc_cnt[gnt_id] + CNT_W'(1);
            if (state == ARB_ISSUE && bus.c_miss) begin
                stall_q <= stall_q + CNT_W'(1);
                if (first_q)
                    miss_cnt[gnt_id] <= miss_cnt[gnt_id] + CNT_W'(1);
            end
        end
    end

    assign p0_acc_cnt  = acc_cnt[0];
    assign p1_acc_cnt  = acc_cnt[1];
    assign p0_miss_cnt = miss_cnt[0];
    assign p1_miss_cnt = miss_cnt[1];
    assign stall_cnt   = stall_q;
`else
    assign p0_acc_cnt  = '0;
    assign p1_acc_cnt  = '0;
    assign p0_miss_cnt = '0;
    assign p1_miss_cnt = '0;
    assign stall_cnt   = '0;
`endif
endmodule

// Per-port completion: registered ready pulse and read-data hold register.
module cache_port_arbiter_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic              rd,
    input  logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic [DATA_W-1:0] rdata
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= done;
            if (done && rd) rdata <= rd_data;
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: vector table plus hand-written miss/reset sequences.
module tb_cache_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [CW-1:0] p0_acc_cnt, p1_acc_cnt, p0_miss_cnt, p1_miss_cnt, stall_cnt;

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .p0_acc_cnt  (p0_acc_cnt),
        .p1_acc_cnt  (p1_acc_cnt),
        .p0_miss_cnt (p0_miss_cnt),
        .p1_miss_cnt (p1_miss_cnt),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic        rst_first;
        logic        q0, q1, miss;
        logic [31:0] rdd;
        logic        rd, wr;
        logic [31:0] addr;
        logic        r0, r1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int a0, input int a1,
                           input int m0, input int m1, input int s);
`ifdef CACHE_ARB_PERF_CNT_EN
        chk({tag, " p0_acc"},  p0_acc_cnt,  a0);
        chk({tag, " p1_acc"},  p1_acc_cnt,  a1);
        chk({tag, " p0_miss"}, p0_miss_cnt, m0);
        chk({tag, " p1_miss"}, p1_miss_cnt, m1);
        chk({tag, " stall"},   stall_cnt,   s);
`else
        chk({tag, " p0_acc"},  p0_acc_cnt,  0);
        chk({tag, " p1_acc"},  p1_acc_cnt,  0);
        chk({tag, " p0_miss"}, p0_miss_cnt, 0);
        chk({tag, " p1_miss"}, p1_miss_cnt, 0);
        chk({tag, " stall"},   stall_cnt,   0);
        if (a0 + a1 + m0 + m1 + s < 0) $display("negative count");
`endif
    endtask

    task automatic drive_idle();
        bus.p0_req = 0; bus.p1_req = 0; bus.p0_we = 0; bus.p1_we = 0;
        bus.p0_addr = 32'h10; bus.p1_addr = 32'h20;
        bus.p0_wdata = 32'hAAAA_0000; bus.p1_wdata = 32'h5555_0000;
        bus.c_miss = 0; bus.c_rd_data = BAD;
    endtask

    // Three cycles of reset with outputs checked while held; returns at the start of an IDLE cycle.
    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        repeat (3) step();
        chk("rst c_rd_req", bus.c_rd_req, 0);
        chk("rst c_wr_req", bus.c_wr_req, 0);
        chk("rst c_addr", bus.c_addr, 0);
        chk("rst c_wr_data", bus.c_wr_data, 0);
        chk("rst ready", {bus.p0_ready, bus.p1_ready}, 0);
        chk("rst rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
        chk_cnt("rst", 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
    endtask

    function automatic vec_t mk(input logic rf, q0, q1, m, input logic [31:0] rdd,
                                input logic rd, wr, input logic [31:0] addr,
                                input logic r0, r1, input logic [31:0] d0, d1);
        vec_t v;
        v.rst_first = rf; v.q0 = q0; v.q1 = q1; v.miss = m; v.rdd = rdd;
        v.rd = rd; v.wr = wr; v.addr = addr; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        // Single P0 read hit: ready two cycles after req is sampled.
        tbl.push_back(mk(1, 1,0,0, 32'hDEAD_BEEF, 0,0,32'h00, 0,0, 32'h0,          32'h0));
        tbl.push_back(mk(0, 1,0,0, 32'hDEAD_BEEF, 1,0,32'h10, 0,0, 32'h0,          32'h0));
        tbl.push_back(mk(0, 1,0,0, 32'hDEAD_BEEF, 0,0,32'h10, 1,0, 32'hDEAD_BEEF,  32'h0));
        tbl.push_back(mk(0, 0,0,0, BAD,           0,0,32'h10, 0,0, 32'hDEAD_BEEF,  32'h0));
        // Both ports saturated from reset: P0, P1, P0, P1, one completion per 3 cycles.
        tbl.push_back(mk(1, 1,1,0, BAD,          0,0,32'h00, 0,0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1,1,0, 32'h1111_0000,1,0,32'h10, 0,0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1,1,0, BAD,          0,0,32'h10, 1,0, 32'h1111_0000, 32'h0));
        tbl.push_back(mk(0, 1,1,0, BAD,          0,0,32'h10, 0,0, 32'h1111_0000, 32'h0));
        tbl.push_back(mk(0, 1,1,0, 32'h2222_0000,1,0,32'h20, 0,0, 32'h1111_0000, 32'h0));
        tbl.push_back(mk(0, 1,1,0, BAD,          0,0,32'h20, 0,1, 32'h1111_0000, 32'h2222_0000));
        tbl.push_back(mk(0, 1,1,0, BAD,          0,0,32'h20, 0,0, 32'h1111_0000, 32'h2222_0000));
        tbl.push_back(mk(0, 1,1,0, 32'h3333_0000,1,0,32'h10, 0,0, 32'h1111_0000, 32'h2222_0000));
        tbl.push_back(mk(0, 1,1,0, BAD,          0,0,32'h10, 1,0, 32'h3333_0000, 32'h2222_0000));
        tbl.push_back(mk(0, 1,1,0, BAD,          0,0,32'h10, 0,0, 32'h3333_0000, 32'h2222_0000));
        tbl.push_back(mk(0, 1,1,0, 32'h4444_0000,1,0,32'h20, 0,0, 32'h3333_0000, 32'h2222_0000));
        tbl.push_back(mk(0, 0,0,0, BAD,          0,0,32'h20, 0,1, 32'h3333_0000, 32'h4444_0000));
        tbl.push_back(mk(0, 0,0,0, BAD,          0,0,32'h20, 0,0, 32'h3333_0000, 32'h4444_0000));
        tbl.push_back(mk(0, 0,0,0, BAD,          0,0,32'h20, 0,0, 32'h3333_0000, 32'h4444_0000));

        step();
        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            bus.p0_req = tbl[i].q0;
            bus.p1_req = tbl[i].q1;
            bus.c_miss = tbl[i].miss;
            bus.c_rd_data = tbl[i].rdd;
            @(negedge clk);
            chk($sformatf("v%0d c_rd_req", i), bus.c_rd_req, tbl[i].rd);
            chk($sformatf("v%0d c_wr_req", i), bus.c_wr_req, tbl[i].wr);
            chk($sformatf("v%0d c_addr", i), bus.c_addr, tbl[i].addr);
            chk($sformatf("v%0d p0_ready", i), bus.p0_ready, tbl[i].r0);
            chk($sformatf("v%0d p1_ready", i), bus.p1_ready, tbl[i].r1);
            chk($sformatf("v%0d p0_rdata", i), bus.p0_rdata, tbl[i].d0);
            chk($sformatf("v%0d p1_rdata", i), bus.p1_rdata, tbl[i].d1);
            step();
        end
        chk_cnt("tie", 2, 2, 0, 0, 0);

        // P1 write held off by 20 miss cycles; P0 activity meanwhile must not leak through.
        do_reset();
        bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h40; bus.p1_wdata = 32'h1234_5678;
        bus.c_miss = 1;
        @(negedge clk);
        chk("miss idle c_wr_req", bus.c_wr_req, 0);
        step();
        for (int k = 1; k <= 21; k++) begin
            bus.c_miss = (k <= 20);
            bus.p0_req = k[0];
            bus.p0_addr = 32'h100 + k;
            @(negedge clk);
            chk($sformatf("miss c%0d c_wr_req", k), bus.c_wr_req, 1);
            chk($sformatf("miss c%0d c_rd_req", k), bus.c_rd_req, 0);
            chk($sformatf("miss c%0d c_addr", k), bus.c_addr, 32'h40);
            chk($sformatf("miss c%0d c_wr_data", k), bus.c_wr_data, 32'h1234_5678);
            chk($sformatf("miss c%0d ready", k), {bus.p0_ready, bus.p1_ready}, 0);
            step();
        end
        bus.p0_req = 1; bus.p0_addr = 32'h80; bus.c_rd_data = 32'h7777_7777;
        @(negedge clk);
        chk("miss resp p1_ready", bus.p1_ready, 1);
        chk("miss resp p0_ready", bus.p0_ready, 0);
        chk("miss resp c_wr_req", bus.c_wr_req, 0);
        chk("miss resp p1_rdata", bus.p1_rdata, 0);
        step();
        bus.p1_req = 0;
        @(negedge clk);
        chk("gap c_rd_req", bus.c_rd_req, 0);
        chk("gap c_addr", bus.c_addr, 32'h40);
        step();
        @(negedge clk);
        chk("p0 after p1 c_rd_req", bus.c_rd_req, 1);
        chk("p0 after p1 c_addr", bus.c_addr, 32'h80);
        step();
        bus.p0_req = 0;
        @(negedge clk);
        chk("p0 after p1 ready", bus.p0_ready, 1);
        chk("p0 after p1 rdata", bus.p0_rdata, 32'h7777_7777);
        step();
        chk_cnt("miss", 1, 1, 0, 1, 20);

        // Reset in the middle of a missing P1 read; post-reset tie must go to P0.
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h20; bus.c_miss = 1;
        step();
        @(negedge clk);
        chk("pre-rst c_rd_req", bus.c_rd_req, 1);
        step();
        rst = 1'b0;
        bus.p0_req = 1; bus.p0_addr = 32'h10;
        #1;
        chk("mid-rst c_rd_req", bus.c_rd_req, 0);
        chk("mid-rst c_addr", bus.c_addr, 0);
        @(negedge clk);
        chk("mid-rst ready", {bus.p0_ready, bus.p1_ready}, 0);
        step();
        rst = 1'b1;
        bus.c_miss = 0;
        @(negedge clk);
        chk("post-rst idle c_rd_req", bus.c_rd_req, 0);
        chk("post-rst idle ready", {bus.p0_ready, bus.p1_ready}, 0);
        step();
        bus.c_rd_data = 32'h9999_0000;
        @(negedge clk);
        chk("post-rst tie c_addr", bus.c_addr, 32'h10);
        chk("post-rst tie c_rd_req", bus.c_rd_req, 1);
        step();
        @(negedge clk);
        chk("post-rst p0_ready", bus.p0_ready, 1);
        chk("post-rst p0_rdata", bus.p0_rdata, 32'h9999_0000);
        chk("post-rst p1_rdata", bus.p1_rdata, 0);
        step();
        bus.p0_req = 0;
        step();
        bus.c_rd_data = 32'hAAAA_5555;
        @(negedge clk);
        chk("post-rst p1 c_addr", bus.c_addr, 32'h20);
        step();
        bus.p1_req = 0;
        @(negedge clk);
        chk("post-rst p1_ready", bus.p1_ready, 1);
        chk("post-rst p1_rdata", bus.p1_rdata, 32'hAAAA_5555);
        step();
        chk_cnt("final", 1, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
